fetcher: RTL
============

// Module: fetcher
// PURPOSE
//  Instruction fetch stage: holds the architectural fetch PC, requests one
//  32-bit instruction at a time from the icache, and consults the branch
//  predictor for conditional branches. It computes the next PC (JAL always
//  taken) and pushes {inst, pc, prediction} into the instruction queue.
//  A ROB flush redirects fetch and discards any in-flight instruction.
// PARAMETERS
//  XLEN      32          data/address width
//  RESET_PC  32'h0       fetch PC after reset
// PORTS
//  clk              in   1     clock
//  rst              in   1     reset, synchronous, active-high
//  rdy              in   1     global enable; low = freeze all state
//  flush            in   1     ROB mispredict/redirect
//  flush_pc         in   XLEN  redirect target, valid with flush
//  fet_icache_en    out  1     icache request pulse
//  fet_icache_addr  out  XLEN  request address
//  icache_ready     in   1     icache_inst valid this cycle
//  icache_inst      in   32    fetched instruction
//  fet_pc           out  XLEN  current fetch PC, to branch predictor
//  bp_pred          in   1     predictor taken bit for fet_pc (combinational)
//  iq_full          in   1     instruction queue cannot accept
//  fet_iq_en        out  1     push pulse to instruction queue
//  fet_iq_inst      out  32    pushed instruction
//  fet_iq_pc        out  XLEN  PC of pushed instruction
//  fet_iq_pred      out  1     1 = predicted taken (branch taken or JAL)
// BEHAVIOUR
//  - All outputs registered except fet_pc (= pc register). Reset: pc=RESET_PC,
//    state=IDLE, fet_icache_en=0, fet_iq_en=0, addr/inst/pc/pred outputs = 0.
//  - rdy=0: no state or output changes (rst also honoured only when rdy=1).
//  - FSM: IDLE -> WAIT -> (IDLE | HOLD); HOLD -> IDLE.
//    IDLE: fet_icache_en<=1, fet_icache_addr<=pc for one cycle; -> WAIT.
//    WAIT: fet_icache_en<=0; on icache_ready latch inst, compute next_pc and
//      pred; if !iq_full: fet_iq_en<=1 with inst/pc/pred, pc<=next_pc, ->IDLE;
//      else -> HOLD with inst/next_pc/pred buffered internally.
//    HOLD: when !iq_full push buffered entry, pc<=next_pc, ->IDLE.
//  - fet_iq_en is a one-cycle pulse; exactly one push per fetched inst.
//  - Next PC (mod 2^XLEN, wrap silently):
//    opcode 1100011 (branch): pred=bp_pred; next = pred ? pc+immB : pc+4,
//      immB = {{20{i[31]}},i[7],i[30:25],i[11:8],1'b0}.
//    opcode 1101111 (JAL): pred=1; next = pc+immJ,
//      immJ = {{12{i[31]}},i[19:12],i[20],i[30:21],1'b0}.
//    all else (incl. JALR): pred=0; next = pc+4 (ROB corrects JALR).
//  - bp_pred sampled in the WAIT cycle icache_ready=1 (fet_pc stable = pc).
//  - flush (highest priority after rst, any state): pc<=flush_pc, ->IDLE,
//    fet_icache_en<=0, fet_iq_en<=0, HOLD buffer dropped; icache_ready in
//    the flush cycle ignored. Next request issues the cycle after flush.
//  - Latency: request to push = icache latency + 1 cycle; min 3 cycles/inst.
// TESTING
//  1 rst then rdy=1 -> cycle 1 fet_icache_en=1 addr=0x0; fet_pc=0x0.
//  2 icache returns 0x00100093 (addi) at pc 0x0, iq_full=0 -> push pc=0x0,
//    pred=0; next request addr=0x4.
//  3 pc=0x100, inst beq imm=-8 (0xFE000CE3), bp_pred=1 -> pred=1, next
//    addr=0xF8; same with bp_pred=0 -> pred=0, next addr=0x104.
//  4 pc=0x200, JAL x0,+0x40 (0x0400006F) -> pred=1, next addr=0x240.
//  5 iq_full=1 at icache_ready -> no push, HOLD; iq_full drops 3 cycles later
//    -> single push same inst/pc, then request at next_pc.
//  6 flush=1 flush_pc=0x80 coincident with icache_ready in WAIT -> no push,
//    next cycle request addr=0x80; flush in HOLD -> buffered entry never pushed.

Source files
------------

// File: rtl/fetcher.sv
// rtl/fetcher.sv - instruction fetch stage: PC, icache request, next-PC predict, IQ push
module fetcher #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            fet_icache_en,
  output logic [XLEN-1:0] fet_icache_addr,
  input  logic            icache_ready,
  input  logic [31:0]     icache_inst,
  output logic [XLEN-1:0] fet_pc,
  input  logic            bp_pred,
  input  logic            iq_full,
  output logic            fet_iq_en,
  output logic [31:0]     fet_iq_inst,
  output logic [XLEN-1:0] fet_iq_pc,
  output logic            fet_iq_pred
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN-1:0] r_pc;
  logic            r_icache_en;
  logic [XLEN-1:0] r_icache_addr;
  logic            r_iq_en;
  logic [31:0]     r_iq_inst;
  logic [XLEN-1:0] r_iq_pc;
  logic            r_iq_pred;
  logic [31:0]     r_buf_inst;
  logic [XLEN-1:0] r_buf_next_pc;
  logic            r_buf_pred;

  logic [6:0]      w_opcode;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic            w_pred;
  logic [XLEN-1:0] w_next_pc;

  logic [XLEN-1:0] w_pc_nxt;
  logic            w_icache_en_nxt;
  logic [XLEN-1:0] w_icache_addr_nxt;
  logic            w_iq_en_nxt;
  logic [31:0]     w_iq_inst_nxt;
  logic [XLEN-1:0] w_iq_pc_nxt;
  logic            w_iq_pred_nxt;
  logic [31:0]     w_buf_inst_nxt;
  logic [XLEN-1:0] w_buf_next_pc_nxt;
  logic            w_buf_pred_nxt;

  // Next-PC predecode of the returning instruction; bp_pred is for the current pc.
  always_comb begin
    w_opcode  = icache_inst[6:0];
    w_imm_b   = {{(XLEN-12){icache_inst[31]}}, icache_inst[7], icache_inst[30:25],
                 icache_inst[11:8], 1'b0};
    w_imm_j   = {{(XLEN-20){icache_inst[31]}}, icache_inst[19:12], icache_inst[20],
                 icache_inst[30:21], 1'b0};
    w_pred    = 1'b0;
    w_next_pc = r_pc + XLEN'(4);
    if (w_opcode == OP_BRANCH) begin
      w_pred = bp_pred;
      if (bp_pred) w_next_pc = r_pc + w_imm_b;
    end else if (w_opcode == OP_JAL) begin
      w_pred    = 1'b1;
      w_next_pc = r_pc + w_imm_j;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_WAIT;
        S_WAIT:  if (icache_ready) w_state_nxt = iq_full ? S_HOLD : S_IDLE;
        S_HOLD:  if (!iq_full) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values of every registered output and of the HOLD buffer.
  always_comb begin
    w_pc_nxt          = r_pc;
    w_icache_en_nxt   = 1'b0;
    w_icache_addr_nxt = r_icache_addr;
    w_iq_en_nxt       = 1'b0;
    w_iq_inst_nxt     = r_iq_inst;
    w_iq_pc_nxt       = r_iq_pc;
    w_iq_pred_nxt     = r_iq_pred;
    w_buf_inst_nxt    = r_buf_inst;
    w_buf_next_pc_nxt = r_buf_next_pc;
    w_buf_pred_nxt    = r_buf_pred;
    if (flush) begin
      w_pc_nxt = flush_pc;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_icache_en_nxt   = 1'b1;
          w_icache_addr_nxt = r_pc;
        end
        S_WAIT: begin
          if (icache_ready) begin
            if (!iq_full) begin
              w_iq_en_nxt   = 1'b1;
              w_iq_inst_nxt = icache_inst;
              w_iq_pc_nxt   = r_pc;
              w_iq_pred_nxt = w_pred;
              w_pc_nxt      = w_next_pc;
            end else begin
              w_buf_inst_nxt    = icache_inst;
              w_buf_next_pc_nxt = w_next_pc;
              w_buf_pred_nxt    = w_pred;
            end
          end
        end
        S_HOLD: begin
          if (!iq_full) begin
            w_iq_en_nxt   = 1'b1;
            w_iq_inst_nxt = r_buf_inst;
            w_iq_pc_nxt   = r_pc;
            w_iq_pred_nxt = r_buf_pred;
            w_pc_nxt      = r_buf_next_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        r_pc          <= RESET_PC;
        r_icache_en   <= 1'b0;
        r_icache_addr <= '0;
        r_iq_en       <= 1'b0;
        r_iq_inst     <= '0;
        r_iq_pc       <= '0;
        r_iq_pred     <= 1'b0;
        r_buf_inst    <= '0;
        r_buf_next_pc <= '0;
        r_buf_pred    <= 1'b0;
      end else begin
        r_pc          <= w_pc_nxt;
        r_icache_en   <= w_icache_en_nxt;
        r_icache_addr <= w_icache_addr_nxt;
        r_iq_en       <= w_iq_en_nxt;
        r_iq_inst     <= w_iq_inst_nxt;
        r_iq_pc       <= w_iq_pc_nxt;
        r_iq_pred     <= w_iq_pred_nxt;
        r_buf_inst    <= w_buf_inst_nxt;
        r_buf_next_pc <= w_buf_next_pc_nxt;
        r_buf_pred    <= w_buf_pred_nxt;
      end
    end
  end

  assign fet_pc          = r_pc;
  assign fet_icache_en   = r_icache_en;
  assign fet_icache_addr = r_icache_addr;
  assign fet_iq_en       = r_iq_en;
  assign fet_iq_inst     = r_iq_inst;
  assign fet_iq_pc       = r_iq_pc;
  assign fet_iq_pred     = r_iq_pred;

endmodule
